// File: rtl/ram_bist_pkg.sv
// Shared types and March C- element table for the RAM BIST initiator.
// Each element lists its sweep direction and up to two operations per address.
package ram_bist_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_M0,
    ST_M1,
    ST_M2,
    ST_M3,
    ST_M4,
    ST_M5,
    ST_DRAIN,
    ST_DONE
  } march_state_t;

  // Background bits; a full data word is this bit replicated.
  localparam logic BG_D0 = 1'b0;
  localparam logic BG_D1 = 1'b1;

  typedef struct packed {
    logic up;
    logic two_ops;
    logic op0_wr;
    logic op0_bg;
    logic op1_wr;
    logic op1_bg;
  } elem_t;

  function automatic elem_t elem_of(input march_state_t s);
    elem_t e;
    e = '0;
    case (s)
      ST_M0: e = '{up: 1'b1, two_ops: 1'b0, op0_wr: 1'b1, op0_bg: BG_D0, op1_wr: 1'b0, op1_bg: BG_D0};
      ST_M1: e = '{up: 1'b1, two_ops: 1'b1, op0_wr: 1'b0, op0_bg: BG_D0, op1_wr: 1'b1, op1_bg: BG_D1};
      ST_M2: e = '{up: 1'b1, two_ops: 1'b1, op0_wr: 1'b0, op0_bg: BG_D1, op1_wr: 1'b1, op1_bg: BG_D0};
      ST_M3: e = '{up: 1'b0, two_ops: 1'b1, op0_wr: 1'b0, op0_bg: BG_D0, op1_wr: 1'b1, op1_bg: BG_D1};
      ST_M4: e = '{up: 1'b0, two_ops: 1'b1, op0_wr: 1'b0, op0_bg: BG_D1, op1_wr: 1'b1, op1_bg: BG_D0};
      ST_M5: e = '{up: 1'b1, two_ops: 1'b0, op0_wr: 1'b0, op0_bg: BG_D0, op1_wr: 1'b0, op1_bg: BG_D0};
      default: e = '0;
    endcase
    return e;
  endfunction

  function automatic march_state_t next_elem(input march_state_t s);
    case (s)
      ST_M0:   return ST_M1;
      ST_M1:   return ST_M2;
      ST_M2:   return ST_M3;
      ST_M3:   return ST_M4;
      ST_M4:   return ST_M5;
      ST_M5:   return ST_DRAIN;
      default: return ST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/ram_bist_addr_gen.sv
// Loadable up/down address counter for the March sweeps.
// Load selects the sweep start (0 or N-1); flags mark the address range ends.
module ram_bist_addr_gen #(
  parameter int addr_width = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  load_max,
  input  logic                  step,
  input  logic                  up,
  output logic [addr_width-1:0] addr,
  output logic                  at_min,
  output logic                  at_max
);

  always_ff @(posedge clk) begin
    if (rst)
      addr <= '0;
    else if (load)
      addr <= load_max ? '1 : '0;
    else if (step)
      addr <= up ? addr + 1'b1 : addr - 1'b1;
  end

  assign at_min = (addr == '0);
  assign at_max = (addr == '1);

endmodule

// File: rtl/ram_march_bist.sv
// March C- BIST initiator for a single-port synchronous RAM: one operation
// per clock, read data compared one cycle later against the expected background.
module ram_march_bist
  import ram_bist_pkg::*;
#(
  parameter int data_width = 32,
  parameter int addr_width = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [addr_width-1:0] fail_addr,
  output logic [data_width-1:0] fail_data,
  output logic [15:0]           err_count,
  output logic                  mem_en,
  output logic                  mem_wr_rdn,
  output logic [addr_width-1:0] mem_addr,
  output logic [data_width-1:0] mem_data_wr,
  input  logic [data_width-1:0] mem_data_rd
);

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  march_state_t          state, state_nxt, nxt_el;
  elem_t                 elem, nxt_info;
  logic                  op_idx, op_idx_nxt;
  logic                  addr_load, addr_load_max, addr_step;
  logic                  at_min, at_max;
  logic [addr_width-1:0] addr;
  logic                  start_ok, last_op, last_addr;
  logic                  cur_wr, cur_bg;
  logic                  wr_last;
  logic [data_width-1:0] data_last;

  logic                  vld_p1, exp_p1, miscmp_p1;
  logic [addr_width-1:0] addr_p1;

  assign elem      = elem_of(state);
  assign nxt_el    = next_elem(state);
  assign nxt_info  = elem_of(nxt_el);
  assign start_ok  = start && (state == ST_IDLE);
  assign last_op   = !elem.two_ops || op_idx;
  assign last_addr = elem.up ? at_max : at_min;

  ram_bist_addr_gen #(.addr_width(addr_width)) u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .load     (addr_load),
    .load_max (addr_load_max),
    .step     (addr_step),
    .up       (elem.up),
    .addr     (addr),
    .at_min   (at_min),
    .at_max   (at_max)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      op_idx <= 1'b0;
    end else begin
      state  <= state_nxt;
      op_idx <= op_idx_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    op_idx_nxt    = op_idx;
    addr_load     = 1'b0;
    addr_load_max = 1'b0;
    addr_step     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_ok) begin
          state_nxt  = ST_M0;
          op_idx_nxt = 1'b0;
          addr_load  = 1'b1;
        end
      end
      ST_M0, ST_M1, ST_M2, ST_M3, ST_M4, ST_M5: begin
        if (last_op) begin
          op_idx_nxt = 1'b0;
          if (last_addr) begin
            state_nxt = nxt_el;
            // Reload for the next sweep so its first op follows with no bubble.
            addr_load     = (state != ST_M5);
            addr_load_max = !nxt_info.up;
          end else begin
            addr_step = 1'b1;
          end
        end else begin
          op_idx_nxt = 1'b1;
        end
      end
      ST_DRAIN: state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_en = 1'b0;
    busy   = 1'b0;
    done   = 1'b0;
    cur_wr = 1'b0;
    cur_bg = 1'b0;
    case (state)
      ST_M0, ST_M1, ST_M2, ST_M3, ST_M4, ST_M5: begin
        mem_en = 1'b1;
        busy   = 1'b1;
        cur_wr = op_idx ? elem.op1_wr : elem.op0_wr;
        cur_bg = op_idx ? elem.op1_bg : elem.op0_bg;
      end
      ST_DRAIN: busy = 1'b1;
      ST_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Bus fields hold their last driven value while the strobe is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_last   <= 1'b0;
      data_last <= '0;
    end else if (mem_en) begin
      wr_last   <= cur_wr;
      data_last <= {data_width{cur_bg}};
    end
  end

  assign mem_addr    = addr;
  assign mem_wr_rdn  = mem_en ? cur_wr : wr_last;
  assign mem_data_wr = mem_en ? {data_width{cur_bg}} : data_last;

  // ---- stage p0 -> p1: register read address and expected background ----
  always_ff @(posedge clk) begin
    if (rst)
      vld_p1 <= 1'b0;
    else
      vld_p1 <= mem_en && !cur_wr;
  end

  always_ff @(posedge clk) begin
    if (mem_en) begin
      exp_p1  <= cur_bg;
      addr_p1 <= addr;
    end
  end

  // ---- stage p1: compare returned read data, update status ----
  assign miscmp_p1 = vld_p1 && (mem_data_rd != {data_width{exp_p1}});

  always_ff @(posedge clk) begin
    if (rst || start_ok) begin
      fail      <= 1'b0;
      fail_addr <= '0;
      fail_data <= '0;
      err_count <= '0;
    end else if (miscmp_p1) begin
      err_count <= sat_inc(err_count);
      if (!fail) begin
        fail      <= 1'b1;
        fail_addr <= addr_p1;
        fail_data <= mem_data_rd;
      end
    end
  end

endmodule
